// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns RV32I loads/stores into aligned word accesses on a
// combinational-read data memory port, with RMW for sub-word stores.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned F3W = 3;

  localparam logic [AW-1:0]  LAST_WORD = AW'(MEM_BYTES - 4);
  localparam logic [F3W-1:0] F3_B  = 3'b000;
  localparam logic [F3W-1:0] F3_H  = 3'b001;
  localparam logic [F3W-1:0] F3_W  = 3'b010;
  localparam logic [F3W-1:0] F3_BU = 3'b100;
  localparam logic [F3W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t r_state, w_state_nxt;

  logic           r_we;
  logic [F3W-1:0] r_funct3;
  logic [1:0]     r_lane;

  logic           r_req_ready, w_req_ready_nxt;
  logic           r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
  logic           r_rsp_err,   w_rsp_err_nxt;
  logic           r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0]  r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0]  r_mem_wdata, w_mem_wdata_nxt;

  logic           w_accept;
  logic [AW-1:0]  w_aligned;
  logic           w_illegal;
  logic           w_misalign;
  logic           w_oor;
  logic           w_err;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [DW-1:0]  w_load_data;
  logic [DW-1:0]  w_merged;

  assign w_accept  = req_valid & r_req_ready;
  assign w_aligned = {req_addr[AW-1:2], 2'b00};

  // Request legality, evaluated on the raw request at accept time
  always_comb begin
    w_illegal = 1'b0;
    if (req_we) begin
      w_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      w_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
  end

  assign w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                    || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign w_oor      = (w_aligned > LAST_WORD);
  assign w_err      = w_illegal | w_misalign | w_oor;

  // Lane select and extension of the word read during ACCESS
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = mem_rdata;
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_load_data = {24'h000000, w_byte};
      F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   w_load_data = {16'h0000, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Sub-word store merge; r_mem_wdata still holds the raw store data here
  always_comb begin
    w_merged = mem_rdata;
    if (r_funct3 == F3_B) begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_mem_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_mem_wdata[7:0];
        2'd2:    w_merged[23:16] = r_mem_wdata[7:0];
        default: w_merged[31:24] = r_mem_wdata[7:0];
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_mem_wdata[15:0];
    end else begin
      w_merged[15:0] = r_mem_wdata[15:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_mem_addr_nxt  = w_aligned;
          w_mem_wdata_nxt = req_wdata;
          if (w_err) begin
            w_state_nxt     = S_RESP;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else begin
            w_state_nxt  = S_ACCESS;
            w_mem_we_nxt = req_we && (req_funct3 == F3_W);
          end
        end
      end
      S_ACCESS: begin
        w_rsp_err_nxt = 1'b0;
        if (!r_we) begin
          w_state_nxt     = S_RESP;
          w_rsp_rdata_nxt = w_load_data;
        end else if (r_funct3 == F3_W) begin
          w_state_nxt     = S_RESP;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_state_nxt     = S_WRITE;
          w_mem_wdata_nxt = w_merged;
          w_mem_we_nxt    = 1'b1;
        end
      end
      S_WRITE: begin
        w_state_nxt     = S_RESP;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Request attributes held for the ACCESS/WRITE phases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_lane   <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_lane   <= req_addr[1:0];
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array memory model plus a
// byte-level reference of load/store semantics, directed and random requests.
module tb_lsu_mem_ctrl;

  localparam int unsigned MEM_BYTES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        pl_en;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;
  int          we_cnt;
  int          n_checks;
  int          n_fail;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, posedge write, plus a preload port
  always @(posedge clk) begin
    if (mem_we && mem_addr <= 32'(MEM_BYTES - 4))
      for (int i = 0; i < 4; i++) mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
    if (pl_en)
      for (int i = 0; i < 4; i++) mem[int'(pl_addr) + i] <= pl_data[8*i +: 8];
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(MEM_BYTES - 4))
      for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = mem[int'(mem_addr) + i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed semantics; stores update ref_mem immediately
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                       output int lat, output int wes);
    int size;
    logic [31:0] al;
    logic [63:0] v;
    logic illegal, mis, oor;
    al   = addr & 32'hFFFF_FFFC;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'd0);
    oor = al > 32'(MEM_BYTES - 4);
    err = illegal | mis | oor;
    rdata = '0;
    wes = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
      rdata = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      wes = 1;
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    for (int i = 0; i < 4; i++) ref_mem[int'(addr) + i] = data[8*i +: 8];
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int w = 0; w < int'(MEM_BYTES); w += 4)
      check($sformatf("%s_w%0d", tag, w),
            {mem[w+3], mem[w+2], mem[w+1], mem[w]},
            {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]});
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic e;
    logic [31:0] rd;
    int lat, wes, w0, n, got_lat;
    model(we, f3, addr, wd, e, rd, lat, wes);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check({tag, "_accept"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    w0 = we_cnt;
    req_valid = 1'b0;
    got_lat = 0;
    for (int c = 1; c <= 6 && got_lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_lat = c;
        check({tag, "_rdata"}, rsp_rdata, rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(e));
        check({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
      end
    end
    check({tag, "_latency"}, 32'(got_lat), 32'(lat));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
    check({tag, "_we_cycles"}, 32'(we_cnt - w0), 32'(wes));
  endtask

  logic [31:0] b2b_exp [3];
  logic [31:0] b2b_addr [3];
  logic [2:0]  b2b_f3 [3];

  initial begin
    logic e;
    int lat, wes, n, cnt;
    n_checks = 0; n_fail = 0; we_cnt = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < int'(MEM_BYTES); w += 4) preload(32'(w), $urandom);

    // Sub-word loads with sign/zero extension
    preload(32'h10, 32'h8899AABB);
    do_req("lb11", 1'b0, 3'b000, 32'h11, '0);
    do_req("lbu11", 1'b0, 3'b100, 32'h11, '0);
    do_req("lh12", 1'b0, 3'b001, 32'h12, '0);
    do_req("lhu12", 1'b0, 3'b101, 32'h12, '0);
    check("lb11_abs", dut.rsp_rdata, 32'h00008899);
    // Word store/load and RMW stores
    do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h12345678);
    do_req("lw20", 1'b0, 3'b010, 32'h20, '0);
    check("lw20_abs", rsp_rdata, 32'h12345678);
    do_req("sb22", 1'b1, 3'b000, 32'h22, 32'hFFFFFFAB);
    do_req("sh20", 1'b1, 3'b001, 32'h20, 32'h0000BEEF);
    do_req("lw20b", 1'b0, 3'b010, 32'h20, '0);
    check("lw20b_abs", rsp_rdata, 32'h12ABBEEF);
    // Error cases
    do_req("lw21", 1'b0, 3'b010, 32'h21, '0);
    do_req("sh23", 1'b1, 3'b001, 32'h23, 32'hDEAD);
    do_req("lw40", 1'b0, 3'b010, 32'h40, '0);
    do_req("ld011", 1'b0, 3'b011, 32'h08, '0);
    do_req("sb3c", 1'b1, 3'b000, 32'h3F, 32'h5A);
    do_req("lw3c", 1'b0, 3'b010, 32'h3C, '0);
    check_mem("dir");

    // Reset during the WRITE phase of an SB
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h25; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_pre_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_we", 32'(mem_we), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (rsp_valid) cnt++; end
    check("rstw_no_rsp", 32'(cnt), 32'd0);
    check_mem("rstw");

    // Back-to-back loads with req_valid held
    b2b_addr[0] = 32'h11; b2b_f3[0] = 3'b000;
    b2b_addr[1] = 32'h22; b2b_f3[1] = 3'b101;
    b2b_addr[2] = 32'h20; b2b_f3[2] = 3'b010;
    for (int k = 0; k < 3; k++) model(1'b0, b2b_f3[k], b2b_addr[k], '0, e, b2b_exp[k], lat, wes);
    @(negedge clk);
    cnt = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          req_valid = 1'b1; req_we = 1'b0; req_funct3 = b2b_f3[k]; req_addr = b2b_addr[k];
          n = 0;
          while (!req_ready && n < 10) begin @(negedge clk); n++; end
          @(posedge clk);
          #1;
        end
        req_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            check("b2b_ready_low", 32'(req_ready), 32'd0);
            if (cnt < 3) check($sformatf("b2b_rdata%0d", cnt), rsp_rdata, b2b_exp[cnt]);
            cnt++;
          end
        end
      end
    join
    check("b2b_count", 32'(cnt), 32'd3);

    // Randomized requests against the reference
    for (int t = 0; t < 80; t++)
      do_req($sformatf("rnd%0d", t), 1'($urandom_range(1)), 3'($urandom_range(7)),
             32'($urandom_range(MEM_BYTES + 7)), $urandom);
    check_mem("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
